// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch stage of the Hack CPU.
// The stage fetches one instruction at a time from ROM with a req/ack
// handshake. It holds that instruction for the execute stage until
// exec_done. On exec_done it steps the PC, or loads it from A when the
// C-instruction jump condition holds.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   a_in             A-register value; low AW bits are the jump target
//   zr, ng           ALU flags (out == 0, out < 0)
//   is_c, jmp        C-instruction flag and jump bits j1 j2 j3
//   exec_done        one-cycle pulse: execute finished current instruction
//   rom_req/rom_addr fetch request and address (rom_addr == pc)
//   rom_ack/rom_data ROM response
//   instr/instr_valid  latched instruction for execute stage
//   pc               address of current or pending instruction
module pc_fetch_unit #(
  parameter int unsigned AW = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   a_in,
  input  logic          zr,
  input  logic          ng,
  input  logic          is_c,
  input  logic [2:0]    jmp,
  input  logic          exec_done,
  output logic          rom_req,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ack,
  input  logic [15:0]   rom_data,
  output logic [15:0]   instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          rom_req_q, rom_req_d;
  logic          take;

  // Bits of A above the ROM address width never reach the PC.
  if (AW < 16) begin : g_a_hi
    logic unused_a_hi;
    assign unused_a_hi = ^a_in[15:AW];
  end

  // j1 -> out < 0, j2 -> out == 0, j3 -> out > 0
  assign take = is_c & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    rom_req_d     = rom_req_q;
    case (state_q)
      IDLE: begin
        state_d   = FETCH;
        rom_req_d = 1'b1;
      end
      FETCH: begin
        if (rom_ack) begin
          instr_d       = rom_data;
          instr_valid_d = 1'b1;
          rom_req_d     = 1'b0;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          instr_valid_d = 1'b0;
          rom_req_d     = 1'b1;
          state_d       = FETCH;
          pc_d          = take ? a_in[AW-1:0] : pc_q + AW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        rom_req_d = 1'b0;
      end
    endcase
  end

  // rom_req is registered alongside the state so it tracks FETCH with no
  // decode logic on the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      rom_req_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      rom_req_q     <= rom_req_d;
    end
  end

  assign rom_req     = rom_req_q;
  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule
